// File: rtl/wb_arb_pkg.sv
// Shared types for the write-back port arbiter.
// State encoding, request bundle and the x0 register index.
package wb_arb_pkg;

  localparam int WB_XLEN = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_HOLD,
    WB_FORCE
  } wb_arb_state_t;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding buffer for a long-latency result
// that lost register-file write-port arbitration.
module wb_hold_buf
  import wb_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [4:0]      load_rd,
  input  logic [XLEN-1:0] load_data,
  output logic            pend_valid,
  output logic [4:0]      pend_rd,
  output logic [XLEN-1:0] pend_data
);

  // capture on load, empty on clear; reset discards contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_rd    <= REG_ZERO;
      pend_data  <= '0;
    end else if (load) begin
      pend_valid <= 1'b1;
      pend_rd    <= load_rd;
      pend_data  <= load_data;
    end else if (clear) begin
      pend_valid <= 1'b0;
      pend_rd    <= REG_ZERO;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline vs long-latency unit.
// Optional WB_ARB_STATS_EN adds conflict/force/drop counters.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_valid,
  input  logic            pipe_reg_write,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  output logic            pipe_stall,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            pend_valid,
  output logic [4:0]      pend_rd
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]     conflict_cnt,
  output logic [15:0]     force_cnt,
  output logic [15:0]     drop_cnt
`endif
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  wb_arb_state_t   state, state_nxt;
  logic [3:0]      wait_cnt, cnt_nxt;
  logic [3:0]      cnt_inc;
  logic            pipe_wr, lu_hs;
  logic            sel_vld;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            buf_load, buf_clr;
  logic            is_drop;
  logic [XLEN-1:0] pend_data;

  assign pipe_stall = (state == WB_FORCE);
  assign lu_ready   = (state == WB_IDLE) & rst_n;
  assign pipe_wr    = pipe_valid & pipe_reg_write & ~pipe_stall;
  assign lu_hs      = lu_valid & lu_ready;
  assign cnt_inc    = wait_cnt + 4'd1;

  wb_hold_buf #(.XLEN(XLEN)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .clear      (buf_clr),
    .load_rd    (lu_rd),
    .load_data  (lu_data),
    .pend_valid (pend_valid),
    .pend_rd    (pend_rd),
    .pend_data  (pend_data)
  );

  // state and starvation counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WB_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
    end
  end

  // next state, write selection and buffer control
  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    sel_vld   = 1'b0;
    sel_rd    = pipe_rd;
    sel_data  = pipe_data;
    buf_load  = 1'b0;
    buf_clr   = 1'b0;
    is_drop   = 1'b0;
    unique case (state)
      WB_IDLE: begin
        if (lu_hs && !pipe_wr) begin
          sel_vld  = 1'b1;
          sel_rd   = lu_rd;
          sel_data = lu_data;
        end else if (lu_hs) begin
          sel_vld   = 1'b1;
          buf_load  = 1'b1;
          cnt_nxt   = 4'd1;
          state_nxt = (MAX_W == 4'd1) ? WB_FORCE : WB_HOLD;
        end else if (pipe_wr) begin
          sel_vld = 1'b1;
        end
      end
      WB_HOLD: begin
        unique case (1'b1)
          !pipe_wr: begin
            sel_vld   = 1'b1;
            sel_rd    = pend_rd;
            sel_data  = pend_data;
            buf_clr   = 1'b1;
            cnt_nxt   = 4'd0;
            state_nxt = WB_IDLE;
          end
          (pipe_rd == pend_rd) && (pipe_rd != REG_ZERO): begin
            sel_vld   = 1'b1;
            buf_clr   = 1'b1;
            is_drop   = 1'b1;
            cnt_nxt   = 4'd0;
            state_nxt = WB_IDLE;
          end
          default: begin
            sel_vld = 1'b1;
            cnt_nxt = cnt_inc;
            if (cnt_inc >= MAX_W) begin
              state_nxt = WB_FORCE;
            end
          end
        endcase
      end
      WB_FORCE: begin
        sel_vld   = 1'b1;
        sel_rd    = pend_rd;
        sel_data  = pend_data;
        buf_clr   = 1'b1;
        cnt_nxt   = 4'd0;
        state_nxt = WB_IDLE;
      end
      default: begin
        cnt_nxt   = 4'd0;
        state_nxt = WB_IDLE;
      end
    endcase
  end

  // registered write port; x0 targets are consumed silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= REG_ZERO;
      rf_wdata <= '0;
    end else if (sel_vld) begin
      rf_we    <= (sel_rd != REG_ZERO);
      rf_waddr <= sel_rd;
      rf_wdata <= sel_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic ev_conf, ev_force;

  assign ev_conf  = (state == WB_IDLE) && (state_nxt == WB_HOLD);
  assign ev_force = (state != WB_FORCE) && (state_nxt == WB_FORCE);

  // saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= 16'd0;
      force_cnt    <= 16'd0;
      drop_cnt     <= 16'd0;
    end else begin
      if (ev_conf && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
      if (ev_force && force_cnt != 16'hFFFF)
        force_cnt <= force_cnt + 16'd1;
      if (is_drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (MAX_WAIT=4).
// Table of per-cycle vectors plus reset sequences.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid, pipe_reg_write;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pend_valid;
  logic [4:0]  pend_rd;
`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_cnt, force_cnt, drop_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.MAX_WAIT(4), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_valid     (pipe_valid),
    .pipe_reg_write (pipe_reg_write),
    .pipe_rd        (pipe_rd),
    .pipe_data      (pipe_data),
    .pipe_stall     (pipe_stall),
    .lu_valid       (lu_valid),
    .lu_ready       (lu_ready),
    .lu_rd          (lu_rd),
    .lu_data        (lu_data),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .pend_valid     (pend_valid),
    .pend_rd        (pend_rd)
`ifdef WB_ARB_STATS_EN
    ,
    .conflict_cnt   (conflict_cnt),
    .force_cnt      (force_cnt),
    .drop_cnt       (drop_cnt)
`endif
  );

  typedef struct {
    logic        pv;
    logic        pw;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ev;
    logic [4:0]  erd;
    logic        st;
    logic        lr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic pv, logic pw, logic [4:0] prd, logic [31:0] pd,
    logic lv, logic [4:0] lrd, logic [31:0] ld,
    logic we, logic [4:0] wa, logic [31:0] wd,
    logic ev, logic [4:0] erd, logic st, logic lr);
    vec_t v;
    v.pv = pv; v.pw = pw; v.prd = prd; v.pd = pd;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.we = we; v.wa = wa; v.wd = wd;
    v.ev = ev; v.erd = erd; v.st = st; v.lr = lr;
    return v;
  endfunction

  task automatic drive(vec_t v);
    pipe_valid     = v.pv;
    pipe_reg_write = v.pw;
    pipe_rd        = v.prd;
    pipe_data      = v.pd;
    lu_valid       = v.lv;
    lu_rd          = v.lrd;
    lu_data        = v.ld;
  endtask

  task automatic check(string name, vec_t v);
    logic bad;
    bad = (rf_we !== v.we) || (pend_valid !== v.ev) ||
          (pipe_stall !== v.st) || (lu_ready !== v.lr);
    if (v.we && (rf_waddr !== v.wa || rf_wdata !== v.wd))
      bad = 1'b1;
    if (v.ev && pend_rd !== v.erd)
      bad = 1'b1;
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got we=%0b wa=%0d wd=%h pv=%0b prd=%0d st=%0b lr=%0b want we=%0b wa=%0d wd=%h pv=%0b prd=%0d st=%0b lr=%0b",
        name, rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd,
        pipe_stall, lu_ready, v.we, v.wa, v.wd, v.ev, v.erd,
        v.st, v.lr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t idle_v, cv;

  initial begin
    idle_v = mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,1);
    rst_n = 1'b0;
    drive(idle_v);
    lu_valid = 1'b1;
    lu_rd    = 5'd5;
    lu_data  = 32'hAAAA;

    // reset: everything low, lu_ready held off
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_%0d", i),
            mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0));
    end
    rst_n = 1'b1;
    #1;
    check("rst_rel", mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,1));
    tick();
    check("rst_lu", mk(0,0,0,0, 0,0,0, 1,5,32'hAAAA, 0,0,0,1));

    // per-cycle vectors
    tbl.push_back(idle_v);
    tbl.push_back(mk(1,1,3,32'h11,  1,7,32'h22,  1,3,32'h11,  1,7,0,0));
    tbl.push_back(mk(0,0,0,0,       0,0,0,       1,7,32'h22,  0,0,0,1));
    tbl.push_back(mk(1,1,10,32'h1234, 0,0,0,     1,10,32'h1234, 0,0,0,1));
    tbl.push_back(mk(1,0,11,32'h5,  0,0,0,       0,0,0,       0,0,0,1));
    tbl.push_back(mk(1,1,0,32'hFF,  0,0,0,       0,0,0,       0,0,0,1));
    tbl.push_back(mk(0,0,0,0,       1,0,32'h77,  0,0,0,       0,0,0,1));
    tbl.push_back(mk(0,0,0,0,       1,12,32'hBEEF, 1,12,32'hBEEF, 0,0,0,1));
    tbl.push_back(mk(1,1,1,32'h101, 1,9,32'h999, 1,1,32'h101, 1,9,0,0));
    tbl.push_back(mk(1,1,2,32'h102, 0,0,0,       1,2,32'h102, 1,9,0,0));
    tbl.push_back(mk(1,1,3,32'h103, 0,0,0,       1,3,32'h103, 1,9,0,0));
    tbl.push_back(mk(1,1,4,32'h104, 0,0,0,       1,4,32'h104, 1,9,1,0));
    tbl.push_back(mk(1,1,5,32'h105, 0,0,0,       1,9,32'h999, 0,0,0,1));
    tbl.push_back(mk(1,1,5,32'h105, 0,0,0,       1,5,32'h105, 0,0,0,1));
    tbl.push_back(mk(1,1,2,32'h202, 1,8,32'h55,  1,2,32'h202, 1,8,0,0));
    tbl.push_back(mk(1,1,8,32'h66,  0,0,0,       1,8,32'h66,  0,0,0,1));
    tbl.push_back(idle_v);
    tbl.push_back(mk(1,1,6,32'h606, 1,0,32'h77,  1,6,32'h606, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,       0,0,0,       0,0,0,       0,0,0,1));
    tbl.push_back(mk(1,0,13,32'h9,  1,14,32'hE,  1,14,32'hE,  0,0,0,1));
    tbl.push_back(idle_v);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      check($sformatf("vec_%0d", i), tbl[i]);
    end

`ifdef WB_ARB_STATS_EN
    n_vec++;
    if (conflict_cnt !== 16'd4 || force_cnt !== 16'd1 ||
        drop_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL stats: got c=%0d f=%0d d=%0d want c=4 f=1 d=1",
               conflict_cnt, force_cnt, drop_cnt);
    end
`endif

    // async reset while a result is buffered
    cv = mk(1,1,3,32'h31, 1,17,32'h71, 1,3,32'h31, 1,17,0,0);
    drive(cv);
    tick();
    check("ar_hold", cv);
    cv = mk(1,1,4,32'h41, 0,0,0, 1,4,32'h41, 1,17,0,0);
    drive(cv);
    tick();
    check("ar_hold2", cv);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_drop", mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0));
    drive(idle_v);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ar_post_%0d", i), idle_v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
